// File: rtl/frequency_pattern_generator.sv
// frequency_pattern_generator: line-scanned 8-bit pixel source with three square-wave pixels
// and start/stop framing, launched by trigger while enabled.
module frequency_pattern_generator #(
    parameter int CLOCK_FREQUENCY     = 100000000,
    parameter int PIXEL_CLOCK_DIVIDER = 4,
    parameter int LINE_LENGTH         = 1024,
    parameter int PIXEL0_INDEX        = 15,
    parameter int PIXEL1_INDEX        = 511,
    parameter int PIXEL2_INDEX        = 1023,
    parameter int PIXEL0_FREQUENCY    = 9000,
    parameter int PIXEL1_FREQUENCY    = 15000,
    parameter int PIXEL2_FREQUENCY    = 25000,
    parameter int RUN_CYCLES          = 1000000,
    parameter int STOP_HOLD_CYCLES    = 16
) (
    input  logic       s00_axi_aclk,
    input  logic       s00_axi_aresetn,
    input  logic       enable,
    input  logic       trigger,
    output logic [7:0] data,
    output logic       pixel_clock,
    output logic       start,
    output logic       stop,
    output logic       busy
);
    localparam int DW  = $clog2(PIXEL_CLOCK_DIVIDER);
    localparam int PW  = ($clog2(LINE_LENGTH) > 10) ? $clog2(LINE_LENGTH) : 10;
    localparam int HP0 = CLOCK_FREQUENCY / (2 * PIXEL0_FREQUENCY);
    localparam int HP1 = CLOCK_FREQUENCY / (2 * PIXEL1_FREQUENCY);
    localparam int HP2 = CLOCK_FREQUENCY / (2 * PIXEL2_FREQUENCY);
    localparam logic [2:0][31:0] HP = {32'(HP2), 32'(HP1), 32'(HP0)};
    localparam logic [2:0][PW-1:0] PIX_IDX = {PW'(PIXEL2_INDEX), PW'(PIXEL1_INDEX), PW'(PIXEL0_INDEX)};
    localparam logic [DW-1:0] DIV_LAST = DW'(PIXEL_CLOCK_DIVIDER - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(PIXEL_CLOCK_DIVIDER / 2);

    if (HP0 < 1 || HP1 < 1 || HP2 < 1) begin : g_hp_check
        $error("channel half period below one clock cycle");
    end

    typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;

    state_t           state_q;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [PW-1:0]    pixel_cnt_q, pixel_cnt_d;
    logic [31:0]      run_cnt_q;
    logic [2:0][31:0] hp_cnt_q;
    logic [2:0]       level_q;
    logic [7:0]       data_q, data_d;
    logic             pclk_q, start_q, stop_q, busy_q;
    logic             div_wrap;

    // Data reloads at the pixel boundary, using the new pixel index and current levels.
    always_comb begin
        div_wrap    = div_cnt_q == DIV_LAST;
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
        pixel_cnt_d = !div_wrap ? pixel_cnt_q
                    : (pixel_cnt_q == PW'(LINE_LENGTH - 1)) ? '0 : pixel_cnt_q + 1'b1;
        data_d      = div_wrap ? 8'h00 : data_q;
        for (int k = 0; k < 3; k++)
            if (div_wrap && level_q[k] && pixel_cnt_d == PIX_IDX[k]) data_d = 8'hFF;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            pixel_cnt_q <= '0;
            run_cnt_q   <= '0;
            hp_cnt_q    <= '0;
            level_q     <= '0;
            data_q      <= 8'h00;
            pclk_q      <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (trigger && enable) begin
                    state_q <= START;
                    start_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                START: begin
                    state_q     <= RUN;
                    div_cnt_q   <= '0;
                    pixel_cnt_q <= '0;
                    run_cnt_q   <= '0;
                    hp_cnt_q    <= '0;
                    level_q     <= '0;
                    data_q      <= 8'h00;
                    pclk_q      <= 1'b0;
                end
                RUN: begin
                    run_cnt_q   <= run_cnt_q + 1'b1;
                    div_cnt_q   <= div_cnt_d;
                    pixel_cnt_q <= pixel_cnt_d;
                    data_q      <= data_d;
                    pclk_q      <= div_cnt_d >= DIV_HALF;
                    for (int k = 0; k < 3; k++) begin
                        hp_cnt_q[k] <= (hp_cnt_q[k] == HP[k] - 1) ? '0 : hp_cnt_q[k] + 1'b1;
                        level_q[k]  <= level_q[k] ^ (hp_cnt_q[k] == HP[k] - 1);
                    end
                    if (!enable || run_cnt_q == 32'(RUN_CYCLES - 1)) begin
                        state_q   <= STOP;
                        run_cnt_q <= '0;
                        stop_q    <= 1'b1;
                        data_q    <= 8'h00;
                        pclk_q    <= 1'b0;
                    end
                end
                STOP: begin
                    run_cnt_q <= run_cnt_q + 1'b1;
                    if (run_cnt_q == 32'(STOP_HOLD_CYCLES - 1)) begin
                        state_q <= IDLE;
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data        = data_q;
    assign pixel_clock = pclk_q;
    assign start       = start_q;
    assign stop        = stop_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_frequency_pattern_generator.sv
// tb_frequency_pattern_generator: directed vector table plus run/abort/reset sequences
// against a closed-form model of the pixel stream.
module tb_frequency_pattern_generator;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       trigger;
    logic [7:0] data;
    logic       pixel_clock, start, stop, busy;
    int         nvec = 0;
    int         nerr = 0;

    typedef struct {
        logic        t;
        logic        e;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[11];

    localparam logic [11:0] IDLE_O  = 12'h000;
    localparam logic [11:0] START_O = 12'h005;
    localparam logic [11:0] STOP_O  = 12'h003;

    frequency_pattern_generator #(
        .CLOCK_FREQUENCY(1000), .PIXEL_CLOCK_DIVIDER(4), .LINE_LENGTH(16),
        .PIXEL0_INDEX(1), .PIXEL1_INDEX(7), .PIXEL2_INDEX(15),
        .PIXEL0_FREQUENCY(100), .PIXEL1_FREQUENCY(50), .PIXEL2_FREQUENCY(25),
        .RUN_CYCLES(200), .STOP_HOLD_CYCLES(4)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .enable(enable), .trigger(trigger),
        .data(data), .pixel_clock(pixel_clock), .start(start), .stop(stop), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected {data, pixel_clock, start, stop, busy} in RUN cycle r (r = 0 is the first RUN cycle).
    function automatic logic [11:0] exp_run(input int r);
        int  p, pix, c;
        logic hi;
        p   = r / 4;
        pix = p % 16;
        c   = 4 * p - 1;
        hi  = (p >= 1) && ((pix == 1  && ((c / 5)  % 2 == 1)) ||
                           (pix == 7  && ((c / 10) % 2 == 1)) ||
                           (pix == 15 && ((c / 20) % 2 == 1)));
        return {hi ? 8'hFF : 8'h00, (r % 4) >= 2, 1'b0, 1'b0, 1'b1};
    endfunction

    task automatic chk(input string name, input int idx, input logic [11:0] exp);
        logic [11:0] act;
        act = {data, pixel_clock, start, stop, busy};
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got {data,pclk,start,stop,busy}=%h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic e);
        trigger = t;
        enable  = e;
        @(posedge clk);
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic kick();
        step(1'b1, 1'b1);
        chk("start", 0, START_O);
    endtask

    // Observes RUN cycles first_r..run_len-1, then the stop hold and return to idle.
    task automatic run_seq(input int first_r, input int run_len, input logic end_en);
        for (int r = first_r; r < run_len; r++) begin
            step(r == 30, 1'b1);
            chk("run", r, exp_run(r));
        end
        for (int s = 0; s < 4; s++) begin
            step(s == 1, s == 0 ? end_en : 1'b1);
            chk("stop", s, STOP_O);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1);
            chk("post_stop_idle", i, IDLE_O);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, IDLE_O};
        tbl[1]  = '{1'b0, 1'b1, IDLE_O};
        tbl[2]  = '{1'b1, 1'b1, START_O};
        tbl[3]  = '{1'b0, 1'b1, 12'h001};
        tbl[4]  = '{1'b1, 1'b1, 12'h001};
        tbl[5]  = '{1'b0, 1'b1, 12'h009};
        tbl[6]  = '{1'b0, 1'b1, 12'h009};
        tbl[7]  = '{1'b0, 1'b1, 12'h001};
        tbl[8]  = '{1'b0, 1'b1, 12'h001};
        tbl[9]  = '{1'b0, 1'b1, 12'h009};
        tbl[10] = '{1'b0, 1'b1, 12'h009};

        rst_n = 1'b0; trigger = 1'b0; enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("in_reset", 0, IDLE_O);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1);
            chk("idle", i, IDLE_O);
        end

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].t, tbl[i].e);
            chk("table", i, tbl[i].exp);
        end
        run_seq(8, 200, 1'b1);

        kick();
        run_seq(0, 200, 1'b0);

        kick();
        run_seq(0, 51, 1'b0);

        kick();
        for (int r = 0; r <= 88; r++) begin
            step(1'b0, 1'b1);
            chk("pre_reset_run", r, exp_run(r));
        end
        rst_n = 1'b0;
        #1;
        chk("async_reset", 0, IDLE_O);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("held_reset", i, IDLE_O);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        chk("after_reset", 0, IDLE_O);
        kick();
        run_seq(0, 200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
